// File: rtl/llki_pkg.sv
// LLKI loader types and TileLink opcode constants.
// Shared by the scratchpad loader and its response checker.
package llki_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } loader_state_e;

  localparam logic [2:0] PUT_FULL = 3'h0;
  localparam logic [2:0] ACK      = 3'h0;
  localparam int LOADER_ERR_W     = 8;
endpackage

// File: rtl/top_pkg.sv
// TileLink-UL field widths shared by all bus agents.
// Data path is 64 bits wide with byte-granular masks.
package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 64;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 8;
  localparam int TL_SZW = 2;
endpackage

// File: rtl/loader_rsp_checker.sv
// In-order D-channel checker: tracks outstanding writes,
// expected source ids and the sticky error / error count.
// Ports: i_clear/i_reject (start outcome), i_push (A load),
// i_d_* (response), o_outstanding, o_err, o_err_cnt.
module loader_rsp_checker
  import top_pkg::*;
  import llki_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clear,
  input  logic                          i_reject,
  input  logic                          i_push,
  input  logic                          i_d_valid,
  input  logic                          i_d_ready,
  input  logic [2:0]                    i_d_opcode,
  input  logic [TL_AIW-1:0]             i_d_source,
  input  logic                          i_d_denied,
  input  logic                          i_d_corrupt,
  output logic [$clog2(MAX_OUTSTANDING):0] o_outstanding,
  output logic                          o_err,
  output logic [LOADER_ERR_W-1:0]       o_err_cnt
);
  localparam int SRC_W = $clog2(MAX_OUTSTANDING);
  localparam int OUT_W = SRC_W + 1;

  logic [OUT_W-1:0]        r_out;
  logic [SRC_W-1:0]        r_exp;
  logic                    r_err;
  logic [LOADER_ERR_W-1:0] r_cnt;

  logic w_fire;
  logic w_have;
  logic w_dec;
  logic w_fail;

  assign w_fire = i_d_valid & i_d_ready;
  assign w_have = (r_out != '0);
  assign w_dec  = w_fire & w_have;

  // A response with nothing in flight is itself a failure
  assign w_fail = w_fire & (i_d_denied | i_d_corrupt |
                  (i_d_opcode != ACK) |
                  (i_d_source != TL_AIW'(r_exp)) |
                  ~w_have);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out <= '0;
      r_exp <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (i_push && !w_dec) begin
        r_out <= r_out + OUT_W'(1);
      end else if (!i_push && w_dec) begin
        r_out <= r_out - OUT_W'(1);
      end
      if (w_fire) begin
        r_exp <= r_exp + SRC_W'(1);
      end
      if (i_reject) begin
        r_err <= 1'b1;
        r_cnt <= '0;
      end else if (i_clear) begin
        r_err <= 1'b0;
        r_cnt <= '0;
      end else if (w_fail) begin
        r_err <= 1'b1;
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + LOADER_ERR_W'(1);
        end
      end
    end
  end

  assign o_outstanding = r_out;
  assign o_err         = r_err;
  assign o_err_cnt     = r_cnt;
endmodule

// File: rtl/scratchpad_loader.sv
// Streams 64-bit words into the LLKI scratchpad as TL-UL
// PutFullData writes. Ports: i_start/i_start_addr/i_word_count
// control, o_busy/o_done/o_err/o_err_cnt status, i_s_* stream,
// o_a_*/i_a_ready A channel, i_d_*/o_d_ready D channel.
module scratchpad_loader
  import top_pkg::*;
  import llki_pkg::*;
#(
  parameter logic [TL_AW-1:0] ADDRESS   = 32'h0000_0000,
  parameter int unsigned DEPTH           = 32'h0000_0100,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH / 8) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [TL_AW-1:0]        i_start_addr,
  input  logic [CNT_W-1:0]        i_word_count,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [LOADER_ERR_W-1:0] o_err_cnt,
  input  logic [TL_DW-1:0]        i_s_data,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  output logic [2:0]              o_a_opcode,
  output logic [2:0]              o_a_param,
  output logic [TL_SZW-1:0]       o_a_size,
  output logic [TL_AIW-1:0]       o_a_source,
  output logic [TL_AW-1:0]        o_a_address,
  output logic [TL_DBW-1:0]       o_a_mask,
  output logic [TL_DW-1:0]        o_a_data,
  output logic                    o_a_corrupt,
  output logic                    o_a_valid,
  input  logic                    i_a_ready,
  input  logic [2:0]              i_d_opcode,
  input  logic [2:0]              i_d_param,
  input  logic [TL_SZW-1:0]       i_d_size,
  input  logic [TL_AIW-1:0]       i_d_source,
  input  logic [TL_DIW-1:0]       i_d_sink,
  input  logic                    i_d_denied,
  input  logic [TL_DW-1:0]        i_d_data,
  input  logic                    i_d_corrupt,
  input  logic                    i_d_valid,
  output logic                    o_d_ready
);
  localparam int SRC_W = $clog2(MAX_OUTSTANDING);
  localparam int OUT_W = SRC_W + 1;
  localparam logic [OUT_W-1:0] MAX_OUT =
    OUT_W'(MAX_OUTSTANDING);
  localparam logic [TL_AW:0] LIMIT =
    {1'b0, ADDRESS} + (TL_AW + 1)'(DEPTH);

  loader_state_e     r_state;
  logic [TL_AW-1:0]  r_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic [SRC_W-1:0]  r_src;
  logic              r_done;
  logic              r_a_valid;
  logic [TL_AW-1:0]  r_a_address;
  logic [TL_DW-1:0]  r_a_data;
  logic [TL_AIW-1:0] r_a_source;
  logic [TL_SZW-1:0] r_a_size;
  logic [TL_DBW-1:0] r_a_mask;

  logic [OUT_W-1:0]  w_outstanding;
  logic [TL_AW:0]    w_end;
  logic              w_bad;
  logic              w_go;
  logic              w_accept;
  logic              w_reject;
  logic              w_load;
  logic              w_push;
  logic              w_unused;

  // Extra bit keeps the end-address check free of wraparound
  assign w_end = {1'b0, i_start_addr} +
                 (TL_AW + 1)'({i_word_count, 3'b000});
  assign w_bad = (i_start_addr[2:0] != 3'b000) |
                 (i_start_addr < ADDRESS) |
                 (w_end > LIMIT);

  assign w_go     = i_start & (r_state == IDLE);
  assign w_accept = w_go & ~w_bad;
  assign w_reject = w_go & w_bad;

  // The A register may refill in the same cycle it drains
  assign w_load = (r_state == ISSUE) &
                  (~r_a_valid | i_a_ready) &
                  (r_remaining != '0) &
                  (w_outstanding < MAX_OUT);
  assign w_push = w_load & i_s_valid;

  assign w_unused = ^{i_d_param, i_d_size, i_d_sink, i_d_data};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_src       <= '0;
      r_done      <= 1'b0;
      r_a_valid   <= 1'b0;
      r_a_address <= '0;
      r_a_data    <= '0;
      r_a_source  <= '0;
      r_a_size    <= '0;
      r_a_mask    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr      <= i_start_addr;
            r_remaining <= i_word_count;
          end
          if (w_accept && (i_word_count != '0)) begin
            r_state <= ISSUE;
          end else if (w_go) begin
            r_done <= 1'b1;
          end
        end
        ISSUE: begin
          if (w_push) begin
            r_a_valid   <= 1'b1;
            r_a_data    <= i_s_data;
            r_a_address <= r_addr;
            r_a_source  <= TL_AIW'(r_src);
            r_a_size    <= TL_SZW'(3);
            r_a_mask    <= '1;
            r_addr      <= r_addr + TL_AW'(8);
            r_remaining <= r_remaining - CNT_W'(1);
            r_src       <= r_src + SRC_W'(1);
          end else if (i_a_ready) begin
            r_a_valid <= 1'b0;
          end
          if ((r_remaining == '0) && !r_a_valid) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_outstanding == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  loader_rsp_checker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_chk (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_accept),
    .i_reject     (w_reject),
    .i_push       (w_push),
    .i_d_valid    (i_d_valid),
    .i_d_ready    (o_d_ready),
    .i_d_opcode   (i_d_opcode),
    .i_d_source   (i_d_source),
    .i_d_denied   (i_d_denied),
    .i_d_corrupt  (i_d_corrupt),
    .o_outstanding(w_outstanding),
    .o_err        (o_err),
    .o_err_cnt    (o_err_cnt)
  );

  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_d_ready   = (r_state == ISSUE) |
                       (r_state == DRAIN);
  assign o_s_ready   = w_load;
  assign o_a_opcode  = PUT_FULL;
  assign o_a_param   = 3'h0;
  assign o_a_corrupt = 1'b0;
  assign o_a_valid   = r_a_valid;
  assign o_a_address = r_a_address;
  assign o_a_data    = r_a_data;
  assign o_a_source  = r_a_source;
  assign o_a_size    = r_a_size;
  assign o_a_mask    = r_a_mask;
endmodule

// File: doc/scratchpad_loader.md
Name: scratchpad_loader

Overview:
- TL-UL master that streams 64-bit words from a valid/ready source into the LLKI scratchpad as sequential PutFullData writes.
- Sits directly upstream of the scratchpad's TL-UL slave port; driven by a control block such as an LLKI key-load sequencer.
- Tracks outstanding writes, checks every D-channel response in order, and reports done and error status.

Parameters:
- ADDRESS, 32'h00000000, scratchpad base byte address.
- DEPTH, 32'h00000100, scratchpad size in bytes; multiple of 8.
- MAX_OUTSTANDING, 4, maximum in-flight A requests; power of 2, between 2 and 8.
- TL_SZW/TL_AIW/TL_AW/TL_DBW/TL_DW, top_pkg values, TL field widths. TL_DW is 64 and TL_DBW is 8.
- CNT_W, $clog2(DEPTH/8)+1, word-count width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE
- start_addr  in  TL_AW  first byte address
- word_count  in  CNT_W  number of 64-bit words to write
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of load or on rejection
- err  out  1  sticky; cleared by the next accepted start
- err_cnt  out  8  failed responses in the current load; saturates at 255
- s_data  in  64  stream word
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- a_opcode/a_param/a_size/a_source/a_address/a_mask/a_data/a_corrupt/a_valid  out  TL widths  TL-UL A channel
- a_ready  in  1
- d_opcode/d_param/d_size/d_source/d_sink/d_denied/d_data/d_corrupt/d_valid  in  TL widths  TL-UL D channel
- d_ready  out  1

Behaviour:
- Reset values:
  - FSM in IDLE; a_valid, s_ready, busy, done, err, d_ready = 0; err_cnt = 0.
  - All A fields = 0, except a_opcode = 3'h0.
  - Internal counters (addr, remaining, outstanding, issue_src, expect_src) = 0.
- Start validation, applied to start in IDLE:
  - Reject if start_addr[2:0] != 0, or start_addr < ADDRESS, or start_addr + 8*word_count > ADDRESS + DEPTH.
  - Rejection: err = 1, err_cnt = 0, done pulses the next cycle, FSM stays IDLE, no bus traffic.
- word_count == 0 with a valid address: done pulses the next cycle with err = 0; no traffic.
- Accepted start: latch addr = start_addr and remaining = word_count; clear err and err_cnt; go to ISSUE.
- Constant A fields: a_opcode = 3'h0 (PutFullData), a_param = 0, a_size = 3, a_mask = 8'hFF, a_corrupt = 0.
- ISSUE state: the A channel is a one-entry output register; a_valid never drops without an a_ready handshake.
- Register load condition: (!a_valid || a_ready) && remaining != 0 && outstanding < MAX_OUTSTANDING.
- s_ready is that load condition (combinational). On s_valid && s_ready:
  - a_data <= s_data, a_address <= addr, a_source <= issue_src, a_valid <= 1.
  - addr += 8, remaining -= 1, issue_src = (issue_src + 1) mod MAX_OUTSTANDING, outstanding += 1.
- Latency: a word accepted in cycle N is presented on A in cycle N+1.
- a_valid clears after a handshake if no new word loads in the same cycle.
- d_ready = 1 in ISSUE and DRAIN, 0 in IDLE. On d_valid:
  - outstanding -= 1.
  - The response is a failure if d_denied, d_corrupt, d_opcode != 3'h0, or d_source != expect_src.
  - A failure sets err and increments err_cnt (saturating).
  - expect_src = (expect_src + 1) mod MAX_OUTSTANDING.
- Responses are in order; outstanding never underflows. A d_valid with outstanding == 0 counts as a failure and leaves the counter at 0.
- A simultaneous A handshake and D response leaves outstanding unchanged.
- ISSUE -> DRAIN when remaining == 0 and a_valid == 0.
- DRAIN -> DONE when outstanding == 0. DONE lasts one cycle (done = 1), then IDLE.
- start outside IDLE is ignored.
- Reset mid-load: immediate return to IDLE with all counters cleared; any late D responses in IDLE are dropped (d_ready = 0).
- busy = (state != IDLE). When done is driven from IDLE after a rejection or empty load, busy stays 0.

Decomposition:
- llki_pkg gets:
  - loader_state_e enum (IDLE, ISSUE, DRAIN, DONE);
  - TL opcode constants PUT_FULL = 3'h0 and ACK = 3'h0;
  - LOADER_ERR_W = 8.
- Use top_pkg widths directly.
- One sub-module: loader_rsp_checker. It holds expect_src, outstanding, and the err/err_cnt logic, and outputs an outstanding count to the issue FSM.

Test Plan:
- start_addr = ADDRESS, word_count = 4, stream 64'h1..64'h4, a_ready = d ready always, a slave responding 1 cycle later:
  - 4 PutFullData at offsets 0x0/0x8/0x10/0x18 with sources 0..3;
  - done once; err = 0; scratchpad readback matches.
- Backpressure: a_ready = 0 for 5 cycles mid-burst:
  - a_valid/a_address/a_data held stable; s_ready = 0;
  - no words lost or duplicated across 8 words.
- Slave withholds D for 10 cycles, MAX_OUTSTANDING = 4, word_count = 8:
  - exactly 4 A handshakes, then s_ready = 0 until the first response;
  - load completes with all 8 written.
- Slave returns d_denied on the 3rd response, word_count = 5:
  - err = 1, err_cnt = 1, done pulses after 5 responses.
- start_addr = ADDRESS + 4, then start_addr = ADDRESS + DEPTH - 8 with word_count = 2:
  - each rejected (done pulse, err = 1, a_valid never asserted).
- Assert rst during DRAIN with 2 outstanding:
  - all outputs return to reset values asynchronously;
  - a subsequent start with word_count = 1 completes cleanly with err = 0.
